// File: rtl/hamming_rx_deframer_if.sv
// Codeword valid/ready channel between the serial deframer and the Hamming decoder.
// The deframer drives the master side and the decoder drives the slave side.
interface hamming_rx_deframer_if;
    logic [6:0] codeword;
    logic       codeword_valid;
    logic       codeword_ready;

    modport master (
        output codeword,
        output codeword_valid,
        input  codeword_ready
    );

    modport slave (
        input  codeword,
        input  codeword_valid,
        output codeword_ready
    );
endinterface

// File: rtl/hamming_rx_deframer.sv
// UART-style receiver for 7-bit Hamming codewords: start bit, 7 code bits LSB first, stop bit.
// Good frames go out on a single-entry valid/ready holding register; framing faults and overruns pulse.
module hamming_rx_deframer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         serial_in,
    hamming_rx_deframer_if.master        cw,
    output logic                         framing_error,
    output logic                         overrun,
    output logic                         busy
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [2:0]    idx_r;
    logic [6:0]    shift_r;
    logic          sync1_r;
    logic          rx_r;

    // Synchronizer, receive FSM, holding register and flag pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r           <= IDLE;
            cnt_r             <= CNT_ZERO;
            idx_r             <= 3'd0;
            shift_r           <= 7'd0;
            sync1_r           <= 1'b1;
            rx_r              <= 1'b1;
            cw.codeword       <= 7'd0;
            cw.codeword_valid <= 1'b0;
            framing_error     <= 1'b0;
            overrun           <= 1'b0;
            busy              <= 1'b0;
        end else begin
            sync1_r       <= serial_in;
            rx_r          <= sync1_r;
            framing_error <= 1'b0;
            overrun       <= 1'b0;

            // A completed transfer empties the register; a stop-edge load below overrides this.
            if (cw.codeword_valid && cw.codeword_ready) begin
                cw.codeword_valid <= 1'b0;
            end else begin
                cw.codeword_valid <= cw.codeword_valid;
            end

            case (state_r)
                IDLE: begin
                    cnt_r <= CNT_ZERO;
                    if (!rx_r) begin
                        state_r <= START;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                end

                START: begin
                    if (cnt_r == HALF_M1) begin
                        cnt_r <= CNT_ZERO;
                        idx_r <= 3'd0;
                        if (rx_r) begin
                            state_r <= IDLE;
                            busy    <= 1'b0;
                        end else begin
                            state_r <= DATA;
                            busy    <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

                DATA: begin
                    if (cnt_r == FULL_M1) begin
                        cnt_r          <= CNT_ZERO;
                        shift_r[idx_r] <= rx_r;
                        if (idx_r == 3'd6) begin
                            state_r <= STOP;
                        end else begin
                            idx_r <= idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

                STOP: begin
                    if (cnt_r == FULL_M1) begin
                        cnt_r   <= CNT_ZERO;
                        state_r <= IDLE;
                        busy    <= 1'b0;
                        if (rx_r) begin
                            // Room exists if empty or the current word leaves on this same edge.
                            if (!cw.codeword_valid || cw.codeword_ready) begin
                                cw.codeword       <= shift_r;
                                cw.codeword_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            framing_error <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

                default: begin
                    state_r <= IDLE;
                    cnt_r   <= CNT_ZERO;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_rx_deframer.sv
// Directed bench for hamming_rx_deframer at CLKS_PER_BIT=4 (H=2): stop sample falls 34 edges after t0,
// which is one edge after send_frame returns (its start bit is driven 3 edges before t0).
module tb_hamming_rx_deframer;

    localparam int CPB = 4;

    logic clk;
    logic reset;
    logic serial_in;
    logic framing_error;
    logic overrun;
    logic busy;

    int tests;
    int fails;

    hamming_rx_deframer_if cw_if ();

    hamming_rx_deframer #(.CLKS_PER_BIT(CPB)) dut (
        .clk           (clk),
        .reset         (reset),
        .serial_in     (serial_in),
        .cw            (cw_if),
        .framing_error (framing_error),
        .overrun       (overrun),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives a whole frame; returns one edge before the stop-sample edge, line left idle high.
    task automatic send_frame(input logic [6:0] d, input logic stop_b);
        serial_in = 1'b0;
        repeat (CPB) step();
        for (int i = 0; i < 7; i++) begin
            serial_in = d[i];
            repeat (CPB) step();
        end
        serial_in = stop_b;
        repeat (CPB) step();
        serial_in = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        serial_in = 1'b1;
        cw_if.codeword_ready = 1'b0;
        repeat (3) step();
        tests++; if (cw_if.codeword !== 7'h00) begin fails++; $display("FAIL reset_codeword got %h exp 00", cw_if.codeword); end
        tests++; if (cw_if.codeword_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", cw_if.codeword_valid); end
        tests++; if (framing_error !== 1'b0) begin fails++; $display("FAIL reset_ferr got %b exp 0", framing_error); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got %b exp 0", overrun); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        reset = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_single_frame();
        cw_if.codeword_ready = 1'b1;
        send_frame(7'h55, 1'b1);
        tests++; if (cw_if.codeword_valid !== 1'b0) begin fails++; $display("FAIL single_early_valid got %b exp 0", cw_if.codeword_valid); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy got %b exp 1", busy); end
        step();
        tests++; if (cw_if.codeword_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %b exp 1", cw_if.codeword_valid); end
        tests++; if (cw_if.codeword !== 7'h55) begin fails++; $display("FAIL single_data got %h exp 55", cw_if.codeword); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_end got %b exp 0", busy); end
        step();
        tests++; if (cw_if.codeword_valid !== 1'b0) begin fails++; $display("FAIL single_valid_drop got %b exp 0", cw_if.codeword_valid); end
        tests++; if (cw_if.codeword !== 7'h55) begin fails++; $display("FAIL single_hold got %h exp 55", cw_if.codeword); end
        repeat (4) step();
    endtask

    task automatic test_backpressure();
        cw_if.codeword_ready = 1'b0;
        send_frame(7'h12, 1'b1);
        send_frame(7'h6D, 1'b1);
        step();
        tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL bp_overrun got %b exp 1", overrun); end
        tests++; if (cw_if.codeword !== 7'h12) begin fails++; $display("FAIL bp_keep got %h exp 12", cw_if.codeword); end
        tests++; if (cw_if.codeword_valid !== 1'b1) begin fails++; $display("FAIL bp_valid got %b exp 1", cw_if.codeword_valid); end
        step();
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL bp_overrun_pulse got %b exp 0", overrun); end
        cw_if.codeword_ready = 1'b1;
        step();
        tests++; if (cw_if.codeword_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got %b exp 0", cw_if.codeword_valid); end
        tests++; if (cw_if.codeword !== 7'h12) begin fails++; $display("FAIL bp_drain_data got %h exp 12", cw_if.codeword); end
        cw_if.codeword_ready = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_back_to_back_load();
        cw_if.codeword_ready = 1'b0;
        send_frame(7'h01, 1'b1);
        step();
        step();
        tests++; if (cw_if.codeword !== 7'h01) begin fails++; $display("FAIL sim_first got %h exp 01", cw_if.codeword); end
        send_frame(7'h7F, 1'b1);
        cw_if.codeword_ready = 1'b1;
        step();
        tests++; if (cw_if.codeword_valid !== 1'b1) begin fails++; $display("FAIL sim_valid got %b exp 1", cw_if.codeword_valid); end
        tests++; if (cw_if.codeword !== 7'h7F) begin fails++; $display("FAIL sim_data got %h exp 7f", cw_if.codeword); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL sim_overrun got %b exp 0", overrun); end
        step();
        tests++; if (cw_if.codeword_valid !== 1'b0) begin fails++; $display("FAIL sim_drain got %b exp 0", cw_if.codeword_valid); end
        cw_if.codeword_ready = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_framing_error();
        cw_if.codeword_ready = 1'b1;
        send_frame(7'h2A, 1'b0);
        step();
        tests++; if (framing_error !== 1'b1) begin fails++; $display("FAIL fe_pulse got %b exp 1", framing_error); end
        tests++; if (cw_if.codeword_valid !== 1'b0) begin fails++; $display("FAIL fe_valid got %b exp 0", cw_if.codeword_valid); end
        step();
        tests++; if (framing_error !== 1'b0) begin fails++; $display("FAIL fe_single got %b exp 0", framing_error); end
        repeat (10) step();
        send_frame(7'h33, 1'b1);
        step();
        tests++; if (cw_if.codeword_valid !== 1'b1) begin fails++; $display("FAIL fe_next_valid got %b exp 1", cw_if.codeword_valid); end
        tests++; if (cw_if.codeword !== 7'h33) begin fails++; $display("FAIL fe_next_data got %h exp 33", cw_if.codeword); end
        repeat (4) step();
    endtask

    task automatic test_false_start();
        logic seen;
        seen = 1'b0;
        cw_if.codeword_ready = 1'b1;
        serial_in = 1'b0;
        step();
        serial_in = 1'b1;
        step();
        step();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL fs_busy got %b exp 1", busy); end
        step();
        step();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL fs_idle got %b exp 0", busy); end
        for (int i = 0; i < 12; i++) begin
            if (framing_error || overrun || cw_if.codeword_valid) seen = 1'b1;
            step();
        end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL fs_flags got %b exp 0", seen); end
    endtask

    task automatic test_reset_mid_frame();
        cw_if.codeword_ready = 1'b0;
        send_frame(7'h0F, 1'b1);
        step();
        step();
        tests++; if (cw_if.codeword_valid !== 1'b1) begin fails++; $display("FAIL rst_held got %b exp 1", cw_if.codeword_valid); end
        serial_in = 1'b0;
        repeat (CPB) step();
        serial_in = 1'b1;
        repeat (2 * CPB) step();
        serial_in = 1'b0;
        repeat (CPB) step();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rst_mid_busy got %b exp 1", busy); end
        reset = 1'b1;
        serial_in = 1'b1;
        step();
        reset = 1'b0;
        tests++; if (cw_if.codeword_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b exp 0", cw_if.codeword_valid); end
        tests++; if (cw_if.codeword !== 7'h00) begin fails++; $display("FAIL rst_data got %h exp 00", cw_if.codeword); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b exp 0", busy); end
        cw_if.codeword_ready = 1'b1;
        repeat (6) step();
        tests++; if (cw_if.codeword_valid !== 1'b0) begin fails++; $display("FAIL rst_no_out got %b exp 0", cw_if.codeword_valid); end
        send_frame(7'h4C, 1'b1);
        tests++; if (cw_if.codeword_valid !== 1'b0) begin fails++; $display("FAIL rst_early got %b exp 0", cw_if.codeword_valid); end
        step();
        tests++; if (cw_if.codeword_valid !== 1'b1) begin fails++; $display("FAIL rst_new_valid got %b exp 1", cw_if.codeword_valid); end
        tests++; if (cw_if.codeword !== 7'h4C) begin fails++; $display("FAIL rst_new_data got %h exp 4c", cw_if.codeword); end
        step();
        tests++; if (cw_if.codeword_valid !== 1'b0) begin fails++; $display("FAIL rst_new_drop got %b exp 0", cw_if.codeword_valid); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        serial_in = 1'b1;
        cw_if.codeword_ready = 1'b0;
        test_reset();
        test_single_frame();
        test_backpressure();
        test_back_to_back_load();
        test_framing_error();
        test_false_start();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
